// File: rtl/lcd_arb_pkg.sv
// Shared definitions for the character-LCD operation arbiter: opcode values,
// FSM state encoding, field widths and the opcode-to-strobe decode.
package lcd_arb_pkg;

   localparam int unsigned OP_W   = 3;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned NCMD   = 5;

   localparam logic [OP_W-1:0] OP_RESET = 3'd0;
   localparam logic [OP_W-1:0] OP_CLEAR = 3'd1;
   localparam logic [OP_W-1:0] OP_HOME  = 3'd2;
   localparam logic [OP_W-1:0] OP_DATA  = 3'd3;
   localparam logic [OP_W-1:0] OP_ADDR  = 3'd4;

   typedef enum logic [2:0] {
      StIdle,
      StInitHi,
      StInitLo,
      StIssue,
      StDone
   } arb_state_e;

   // Strobe vector bit order: {addr, data, home, clear, reset}; zero for invalid opcodes.
   function automatic logic [NCMD-1:0] op_strobe(input logic [OP_W-1:0] op);
      logic [NCMD-1:0] s;
      s = '0;
      case (op)
         OP_RESET: s = 5'b00001;
         OP_CLEAR: s = 5'b00010;
         OP_HOME:  s = 5'b00100;
         OP_DATA:  s = 5'b01000;
         OP_ADDR:  s = 5'b10000;
         default:  s = '0;
      endcase
      return s;
   endfunction

   // Only DATA and ADDR carry a byte to the controller.
   function automatic logic op_has_byte(input logic [OP_W-1:0] op);
      return (op == OP_DATA) || (op == OP_ADDR);
   endfunction

endpackage

// File: rtl/lcd_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module lcd_rr_pick
   import lcd_arb_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] win,
   output logic [PW-1:0]   win_idx,
   output logic            valid
);

   // Scan NREQ positions starting at ptr; the first hit wins.
   always_comb begin
      int unsigned pos;
      logic [PW-1:0] sel;
      win     = '0;
      win_idx = '0;
      valid   = 1'b0;
      pos     = 0;
      sel     = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         pos = 32'(ptr) + k;
         if (pos >= NREQ) pos = pos - NREQ;
         sel = PW'(pos);
         if (!valid && req[sel]) begin
            valid    = 1'b1;
            win[sel] = 1'b1;
            win_idx  = sel;
         end
      end
   end

endmodule

// File: rtl/lcd_op_arbiter.sv
// Round-robin arbiter sharing one clplcd controller among NREQ client FSMs.
// Each grant runs: init pulse, command strobe held until the matching ack, done pulse.
// Optional ack timeout enabled by defining LCD_TIMEOUT_EN (limit TMO_CYC cycles).
module lcd_op_arbiter
   import lcd_arb_pkg::*;
#(
   parameter int unsigned NREQ    = 2,
   parameter int unsigned TMO_CYC = 2000000
) (
   input  logic                     CLK,
   input  logic                     RSTN,
   input  logic [NREQ-1:0]          req,
   input  logic [OP_W*NREQ-1:0]     op,
   input  logic [BYTE_W*NREQ-1:0]   din,
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          done,
   output logic                     err,
   output logic                     busy,
   output logic                     initlcd,
   output logic                     resetlcd,
   output logic                     clearlcd,
   output logic                     homelcd,
   output logic                     datalcd,
   output logic                     addrlcd,
   output logic [BYTE_W-1:0]        lcddatin,
   input  logic                     lcdreset,
   input  logic                     lcdclear,
   input  logic                     lcdhome,
   input  logic                     lcddata,
   input  logic                     lcdaddr
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   if (NREQ < 1 || NREQ > 8 || TMO_CYC < 1) begin : g_param_chk
      $error("lcd_op_arbiter: NREQ must be 1..8 and TMO_CYC at least 1");
   end

   arb_state_e          state_q, state_d;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [NREQ-1:0]     gnt_q, gnt_d;
   logic [NREQ-1:0]     done_q, done_d;
   logic                err_q, err_d;
   logic                init_q, init_d;
   logic [NCMD-1:0]     strb_q, strb_d;
   logic [BYTE_W-1:0]   datin_q, datin_d;
   logic [OP_W-1:0]     op_q, op_d;
   logic [BYTE_W-1:0]   din_q, din_d;

   logic [NREQ-1:0]     pick_win;
   logic [PW-1:0]       pick_idx;
   logic                pick_valid;
   logic [OP_W-1:0]     op_sel;
   logic [BYTE_W-1:0]   din_sel;
   logic [NCMD-1:0]     ack;

`ifdef LCD_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TMO_CYC + 1);
   logic [TW-1:0]       tmo_q, tmo_d;
`endif

   lcd_rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .req     (req),
      .ptr     (ptr_q),
      .win     (pick_win),
      .win_idx (pick_idx),
      .valid   (pick_valid)
   );

   assign ack = {lcdaddr, lcddata, lcdhome, lcdclear, lcdreset};

   // Route the winning client's opcode and byte to the latches.
   always_comb begin
      op_sel  = '0;
      din_sel = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (pick_win[i]) begin
            op_sel  = op[i*OP_W +: OP_W];
            din_sel = din[i*BYTE_W +: BYTE_W];
         end
      end
   end

   // Next-state and registered-output logic for the transaction sequence.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      err_d   = 1'b0;
      init_d  = 1'b0;
      strb_d  = strb_q;
      datin_d = datin_q;
      op_d    = op_q;
      din_d   = din_q;
`ifdef LCD_TIMEOUT_EN
      tmo_d   = tmo_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               gnt_d   = pick_win;
               op_d    = op_sel;
               din_d   = din_sel;
               init_d  = 1'b1;
               ptr_d   = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
               state_d = StInitHi;
            end
         end
         StInitHi: begin
            state_d = StInitLo;
         end
         StInitLo: begin
            if (op_strobe(op_q) != '0) begin
               strb_d  = op_strobe(op_q);
               datin_d = op_has_byte(op_q) ? din_q : '0;
`ifdef LCD_TIMEOUT_EN
               tmo_d   = '0;
`endif
               state_d = StIssue;
            end else begin
               // Invalid opcode: finish with error, never touch the controller.
               done_d  = gnt_q;
               err_d   = 1'b1;
               gnt_d   = '0;
               state_d = StDone;
            end
         end
         StIssue: begin
            if ((strb_q & ack) != '0) begin
               strb_d  = '0;
               done_d  = gnt_q;
               gnt_d   = '0;
               state_d = StDone;
            end
`ifdef LCD_TIMEOUT_EN
            else if (tmo_q == TW'(TMO_CYC - 1)) begin
               strb_d  = '0;
               done_d  = gnt_q;
               err_d   = 1'b1;
               gnt_d   = '0;
               state_d = StDone;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
`endif
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers; reset aborts any transaction without a done.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         err_q   <= 1'b0;
         init_q  <= 1'b0;
         strb_q  <= '0;
         datin_q <= '0;
         op_q    <= '0;
         din_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
         init_q  <= init_d;
         strb_q  <= strb_d;
         datin_q <= datin_d;
         op_q    <= op_d;
         din_q   <= din_d;
      end
   end

`ifdef LCD_TIMEOUT_EN
   // Ack timeout counter, only meaningful while in StIssue.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`endif

   assign gnt      = gnt_q;
   assign done     = done_q;
   assign err      = err_q;
   assign busy     = (state_q != StIdle);
   assign initlcd  = init_q;
   assign resetlcd = strb_q[0];
   assign clearlcd = strb_q[1];
   assign homelcd  = strb_q[2];
   assign datalcd  = strb_q[3];
   assign addrlcd  = strb_q[4];
   assign lcddatin = datin_q;

endmodule

// File: tb/tb_lcd_op_arbiter.sv
// Randomized bench for lcd_op_arbiter with a transaction-level reference model
// (pending set + round-robin pointer) and an inline clplcd ack responder.
module tb_lcd_op_arbiter;

   localparam int unsigned NREQ    = 3;
   localparam int unsigned TMO_CYC = 16;

   logic                CLK = 1'b0;
   logic                RSTN;
   logic [NREQ-1:0]     req;
   logic [3*NREQ-1:0]   op;
   logic [8*NREQ-1:0]   din;
   logic [NREQ-1:0]     gnt;
   logic [NREQ-1:0]     done;
   logic                err;
   logic                busy;
   logic                initlcd;
   logic                resetlcd, clearlcd, homelcd, datalcd, addrlcd;
   logic [7:0]          lcddatin;
   logic [4:0]          ack_v;
   logic [4:0]          strb;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state
   int unsigned m_op[NREQ];
   logic [7:0]  m_din[NREQ];
   int          ptr_m;
   logic [7:0]  last_datin;

   always #5 CLK = ~CLK;

   assign strb = {addrlcd, datalcd, homelcd, clearlcd, resetlcd};

   lcd_op_arbiter #(
      .NREQ    (NREQ),
      .TMO_CYC (TMO_CYC)
   ) dut (
      .CLK      (CLK),
      .RSTN     (RSTN),
      .req      (req),
      .op       (op),
      .din      (din),
      .gnt      (gnt),
      .done     (done),
      .err      (err),
      .busy     (busy),
      .initlcd  (initlcd),
      .resetlcd (resetlcd),
      .clearlcd (clearlcd),
      .homelcd  (homelcd),
      .datalcd  (datalcd),
      .addrlcd  (addrlcd),
      .lcddatin (lcddatin),
      .lcdreset (ack_v[0]),
      .lcdclear (ack_v[1]),
      .lcdhome  (ack_v[2]),
      .lcddata  (ack_v[3]),
      .lcdaddr  (ack_v[4])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // First pending client at or after the pointer, wrapping.
   function automatic int pick(input logic [NREQ-1:0] p, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (ptr + k) % NREQ;
         if (p[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic set_client(input int i, input int unsigned o, input logic [7:0] d);
      m_op[i]         = o;
      m_din[i]        = d;
      op[3*i +: 3]    = o[2:0];
      din[8*i +: 8]   = d;
      req[i]          = 1'b1;
   endtask

   function automatic int unsigned rand_op();
      if ($urandom_range(0, 5) == 0) return $urandom_range(5, 7);
      return $urandom_range(0, 4);
   endfunction

   task automatic maybe_join();
      for (int i = 0; i < NREQ; i++)
         if (!req[i] && $urandom_range(0, 2) == 0)
            set_client(i, rand_op(), 8'($urandom_range(0, 255)));
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RSTN  = 1'b0;
      req   = '0;
      ack_v = '0;
      @(negedge CLK);
      check("rst_busy", busy, 0);
      check("rst_gnt", gnt, 0);
      check("rst_datin", lcddatin, 0);
      RSTN       = 1'b1;
      ptr_m      = 0;
      last_datin = 8'h00;
   endtask

   // One arbitration slot, entered at a negedge with the DUT idle.
   task automatic serve_one(input int keep_pct, input int fixed_d);
      int         w, d;
      logic [4:0] es;
      logic [7:0] ed;
      if (req == '0) begin
         @(negedge CLK);
         check("idle_gnt", gnt, 0);
         check("idle_busy", busy, 0);
         return;
      end
      w     = pick(req, ptr_m);
      ptr_m = (w + 1) % NREQ;
      @(negedge CLK);
      check("gnt", gnt, 1 << w);
      check("initlcd_hi", initlcd, 1);
      check("busy", busy, 1);
      @(negedge CLK);
      check("initlcd_lo", initlcd, 0);
      check("strb_pre", strb, 0);
      check("gnt_hold", gnt, 1 << w);
      if ($urandom_range(0, 5) == 0) req[w] = 1'b0;
      @(negedge CLK);
      if (m_op[w] >= 5) begin
         check("inv_done", done, 1 << w);
         check("inv_err", err, 1);
         check("inv_gnt", gnt, 0);
         check("inv_strb", strb, 0);
         check("inv_datin", lcddatin, last_datin);
      end else begin
         es         = 5'(1 << m_op[w]);
         ed         = (m_op[w] >= 3) ? m_din[w] : 8'h00;
         last_datin = ed;
         check("strb", strb, es);
         check("datin", lcddatin, ed);
         check("done_early", done, 0);
         d = (fixed_d >= 0) ? fixed_d : $urandom_range(0, 4);
         for (int k = 0; k < d; k++) begin
            // A non-matching ack must be ignored.
            ack_v = 5'(1 << ((m_op[w] + $urandom_range(1, 4)) % 5));
            @(negedge CLK);
            check("strb_hold", strb, es);
            check("no_done", done, 0);
         end
         ack_v = es;
         @(negedge CLK);
         ack_v = '0;
         check("done", done, 1 << w);
         check("err0", err, 0);
         check("strb_off", strb, 0);
         check("gnt_off", gnt, 0);
      end
      if (req[w] && $urandom_range(0, 99) >= keep_pct) req[w] = 1'b0;
      @(negedge CLK);
      check("done_pulse", done, 0);
      check("err_pulse", err, 0);
      check("busy_idle", busy, 0);
      check("datin_hold", lcddatin, last_datin);
   endtask

   initial begin
      int cnt;
      RSTN       = 1'b0;
      req        = '0;
      op         = '0;
      din        = '0;
      ack_v      = '0;
      ptr_m      = 0;
      last_datin = 8'h00;
      repeat (2) @(negedge CLK);
      check("rst_gnt0", gnt, 0);
      check("rst_done0", done, 0);
      check("rst_err0", err, 0);
      check("rst_busy0", busy, 0);
      check("rst_init0", initlcd, 0);
      check("rst_strb0", strb, 0);
      check("rst_datin0", lcddatin, 0);
      RSTN = 1'b1;

      // Single DATA transaction, ack five cycles into the strobe.
      set_client(0, 3, 8'h35);
      serve_one(0, 5);

      // Contention from reset: both held, grants must alternate.
      do_reset();
      set_client(0, 3, 8'h41);
      set_client(1, 4, 8'h80);
      repeat (6) serve_one(100, -1);
      req = '0;

      // Invalid opcode.
      set_client(1, 6, 8'h00);
      serve_one(0, -1);

      // Randomized traffic.
      for (int it = 0; it < 150; it++) begin
         maybe_join();
         serve_one(30, -1);
      end

      // Reset in the middle of an ADDR strobe.
      req = '0;
      @(negedge CLK);
      set_client(2, 4, 8'hc3);
      cnt = 0;
      while (!addrlcd && cnt < 10) begin
         @(negedge CLK);
         cnt++;
      end
      check("addr_seen", addrlcd, 1);
      #2 RSTN = 1'b0;
      #1;
      check("arst_addr", addrlcd, 0);
      check("arst_gnt", gnt, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      req = '0;
      @(negedge CLK);
      check("arst_nodone", done, 0);
      RSTN       = 1'b1;
      ptr_m      = 0;
      last_datin = 8'h00;
      for (int i = 0; i < NREQ; i++) set_client(i, 3, 8'(8'h10 + i));
      repeat (NREQ) serve_one(0, -1);

      // No ack at all.
      req = '0;
      @(negedge CLK);
      set_client(0, 3, 8'h77);
      repeat (3) @(negedge CLK);
      check("hang_strb", datalcd, 1);
`ifdef LCD_TIMEOUT_EN
      cnt = 1;
      @(negedge CLK);
      while (datalcd && cnt < 40) begin
         cnt++;
         @(negedge CLK);
      end
      check("tmo_cycles", cnt, TMO_CYC);
      check("tmo_done", done, 1);
      check("tmo_err", err, 1);
`else
      cnt = 0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge CLK);
         if (datalcd && done == '0) cnt++;
      end
      check("hang_cycles", cnt, 1000);
`endif
      do_reset();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
